// File: rtl/rot_sched_pkg.sv
// Shared types and helpers for the rotate scheduler.
// Used by rot_scheduler and rr_arbiter; optional build macro ROT_SCHED_PRIO_EN
// is consumed by rr_arbiter.
package rot_sched_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned SHIFT_W  = 3;
  // Widest requester index (NUM_REQ <= 8)
  localparam int unsigned ID_MAX_W = 3;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [SHIFT_W-1:0]  shift;
    logic [ID_MAX_W-1:0] id;
  } stage_t;

  // Left-rotate: out[k] = in[(k - s) mod DATA_W]
  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] d,
                                             input logic [SHIFT_W-1:0] s);
    logic [2*DATA_W-1:0] w;
    w = {d, d} << s;
    return w[2*DATA_W-1:DATA_W];
  endfunction

endpackage

// File: rtl/rot_scheduler_rr_arbiter.sv
// Round-robin arbiter with internal last-grant pointer.
// ROT_SCHED_PRIO_EN: requester 0 wins whenever it requests; the others
// rotate among themselves and the pointer only tracks their grants.
module rr_arbiter
  import rot_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] gidx;
  logic            found;

  // Search from last_grant+1, first requesting index wins
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
`ifdef ROT_SCHED_PRIO_EN
    if (req[0]) begin
      grant[0] = 1'b1;
      found    = 1'b1;
    end
`endif
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      int unsigned idx;
      idx = (32'(last_grant) + 1 + off) % NUM_REQ;
`ifdef ROT_SCHED_PRIO_EN
      if (!found && idx != 0 && req[idx]) begin
`else
      if (!found && req[idx]) begin
`endif
        grant[idx] = 1'b1;
        gidx       = ID_W'(idx);
        found      = 1'b1;
      end
    end
  end

  // Pointer moves only on an accepted transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
`ifdef ROT_SCHED_PRIO_EN
      if (advance && found && gidx != '0) last_grant <= gidx;
`else
      if (advance && found) last_grant <= gidx;
`endif
    end
  end

endmodule

// File: rtl/rot_scheduler.sv
// Rotate scheduler: round-robin picks one requester's operand into stage 1,
// stage 2 holds the left-rotated result until the downstream accepts it.
// Build option ROT_SCHED_PRIO_EN (see rr_arbiter) gives requester 0 priority.
module rot_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*3-1:0]      req_shift,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id,
  output logic                      busy
);

  import rot_sched_pkg::*;

  stage_t              s1;
  logic                s1_valid;
  logic                s2_valid;
  logic [DATA_W-1:0]   s2_data;
  logic [ID_W-1:0]     s2_id;

  logic                s2_take;
  logic                s1_open;
  logic [NUM_REQ-1:0]  arb_grant;
  stage_t              sel;

  // Stage 2 can load when empty or draining; stage 1 when empty or advancing.
  // Grants are held off during reset so nothing transfers while rst_n is low.
  always_comb begin
    s2_take   = !s2_valid || resp_ready;
    s1_open   = rst_n && (!s1_valid || s2_take);
    req_ready = s1_open ? arb_grant : '0;
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (|req_ready),
    .grant   (arb_grant)
  );

  // Mux the granted requester's operand into a stage entry
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel.data  = req_data[i*DATA_W +: DATA_W];
        sel.shift = req_shift[i*3 +: 3];
        sel.id    = ID_MAX_W'(i);
      end
    end
  end

  // Stage 1: operand register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_open) begin
      s1_valid <= |req_ready;
      if (|req_ready) s1 <= sel;
    end
  end

  // Stage 2: rotated result register, held under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_id    <= '0;
    end else if (s2_take) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= rotl(s1.data, s1.shift);
        s2_id   <= ID_W'(s1.id);
      end
    end
  end

  // Output mapping
  always_comb begin
    resp_valid = s2_valid;
    resp_data  = s2_data;
    resp_id    = s2_id;
    busy       = s1_valid || s2_valid;
  end

endmodule

// File: tb/tb_rot_scheduler.sv
// Self-checking bench for rot_scheduler against a queue-based reference:
// an elastic buffer of capacity two where an entry becomes visible one edge
// after acceptance, plus a round-robin pick computed from the request vector.
module tb_rot_scheduler;

  localparam int N = 4;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*8-1:0]   req_data;
  logic [N*3-1:0]   req_shift;
  logic             resp_valid;
  logic             resp_ready;
  logic [7:0]       resp_data;
  logic [1:0]       resp_id;
  logic             busy;

  rot_scheduler #(.NUM_REQ(N), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_shift  (req_shift),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         id;
    int         age;
  } ent_t;

  ent_t q[$];
  int   last;
  int   vectors;
  int   miscompares;
  int   last_eg;
  int   obs_xfer;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_rot(input logic [7:0] d, input int s);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = d[(k - s + 8) % 8];
    return r;
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int from);
    int g;
    g = -1;
`ifdef ROT_SCHED_PRIO_EN
    if (v[0]) g = 0;
    for (int o = 1; o <= N; o++) begin
      int j;
      j = (from + o) % N;
      if (g < 0 && j != 0 && v[j]) g = j;
    end
`else
    for (int o = 1; o <= N; o++) begin
      int j;
      j = (from + o) % N;
      if (g < 0 && v[j]) g = j;
    end
`endif
    return g;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic [2:0] s);
    req_valid[i]       = v;
    req_data[i*8 +: 8] = d;
    req_shift[i*3 +: 3] = s;
  endtask

  // One clock cycle: check outputs against the model, then advance the model
  task automatic step();
    logic        exp_rv;
    logic        pop;
    logic        can;
    int          eg;
    logic [N-1:0] exp_rdy;
    ent_t        e;
    #1;
    exp_rv = (q.size() > 0) && (q[0].age >= 1);
    pop    = exp_rv && resp_ready;
    can    = (q.size() < 2) || pop;
    eg     = can ? pick(req_valid, last) : -1;
    exp_rdy = '0;
    if (eg >= 0) exp_rdy[eg] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("resp_valid", 32'(resp_valid), 32'(exp_rv));
    check("busy", 32'(busy), 32'(q.size() > 0));
    if (exp_rv) begin
      check("resp_data", 32'(resp_data), 32'(q[0].data));
      check("resp_id", 32'(resp_id), 32'(q[0].id));
    end
    obs_xfer += $countones(req_ready & req_valid);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    foreach (q[i]) q[i].age++;
    if (eg >= 0) begin
      e.data = ref_rot(req_data[eg*8 +: 8], int'(req_shift[eg*3 +: 3]));
      e.id   = eg;
      e.age  = 0;
      q.push_back(e);
`ifdef ROT_SCHED_PRIO_EN
      if (eg != 0) last = eg;
`else
      last = eg;
`endif
    end
    last_eg = eg;
    @(negedge clk);
  endtask

  // Refresh the operand of the requester just granted, keep the rest held
  task automatic refresh_granted();
    if (last_eg >= 0)
      set_req(last_eg, 1'b1, 8'($urandom), 3'($urandom));
  endtask

  task automatic drain(input int n);
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    obs_xfer    = 0;
    last_eg     = -1;
    last        = N - 1;
    rst_n       = 1'b0;
    resp_ready  = 1'b1;
    req_valid   = '1;
    req_data    = '0;
    req_shift   = '0;

    // Reset values, with every requester asserting valid
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_resp_data", 32'(resp_data), 32'h0);
    check("rst_resp_id", 32'(resp_id), 32'h0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;

    // Single request: 0x81 rotated by 1
    set_req(0, 1'b1, 8'h81, 3'd1);
    step();
    req_valid = '0;
    step();
    check("r032_valid", 32'(resp_valid), 32'h1);
    check("r032_data", 32'(resp_data), 32'h03);
    check("r032_id", 32'(resp_id), 32'h0);
    drain(3);

    // Shift sweep on 0x01
    for (int s = 0; s < 8; s++) begin
      set_req(0, 1'b1, 8'h01, 3'(s));
      step();
    end
    drain(4);

    // All requesters valid, downstream always ready
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'($urandom), 3'($urandom));
    for (int c = 0; c < 12; c++) begin
      step();
      refresh_granted();
    end
    drain(4);

    // Backpressure with four pending requests
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'($urandom), 3'($urandom));
    resp_ready = 1'b0;
    obs_xfer = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      refresh_granted();
    end
    check("stall_accepts", 32'(obs_xfer), 32'd2);
    resp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      if (last_eg >= 0) req_valid[last_eg] = 1'b0;
    end
    drain(4);

    // Reset with both stages full
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'($urandom), 3'($urandom));
    resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check("full_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", 32'(resp_valid), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    q.delete();
    last = N - 1;
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    step();
    check("post_rst_grant", 32'(last_eg), 32'd0);
    refresh_granted();
    for (int c = 0; c < 4; c++) begin
      step();
      refresh_granted();
    end
    drain(4);

`ifdef ROT_SCHED_PRIO_EN
    // Requester 0 holds priority over requester 2
    set_req(0, 1'b1, 8'h11, 3'd2);
    set_req(2, 1'b1, 8'h22, 3'd3);
    for (int c = 0; c < 4; c++) begin
      step();
      check("prio_grant0", 32'(last_eg), 32'd0);
    end
    req_valid[0] = 1'b0;
    step();
    check("prio_then2", 32'(last_eg), 32'd2);
    drain(4);
`endif

    // Random traffic; an ungranted valid request keeps its operand
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && last_eg != i)) begin
          if (i == last_eg || !req_valid[i])
            set_req(i, 1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom));
        end
      end
      resp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    drain(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
